parallel_to_serial: RTL and testbench

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

---
 rtl/parallel_to_serial_pkg.sv | 19 +
 rtl/parallel_to_serial_if.sv | 21 ++
 rtl/parallel_to_serial_hold_buf.sv | 41 ++++
 rtl/parallel_to_serial.sv | 101 ++++++++++
 tb/tb_parallel_to_serial.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/parallel_to_serial_pkg.sv
// Shared types and constants for the parallel/serial converter pair.
// Package name is kept as p2s_pkg so the receiver side can import the same defaults.
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_e;

  localparam int unsigned P2S_DATA_W    = 8;
  localparam int unsigned S2P_DATA_W    = P2S_DATA_W;
  localparam bit          P2S_MSB_FIRST = 1'b1;

  // Bit-counter width; floor of 1 keeps the counter legal for tiny words.
  function automatic int unsigned p2s_cnt_w(input int unsigned data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/parallel_to_serial_if.sv
// Handshake bundle for the parallel_to_serial word input and serial bit output.
interface parallel_to_serial_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] din_parallel;
  logic              din_valid;
  logic              din_ready;
  logic              dout_serial;
  logic              dout_valid;
  logic              dout_last;

  modport master (
    output din_parallel, din_valid,
    input  din_ready, dout_serial, dout_valid, dout_last
  );

  modport slave (
    input  din_parallel, din_valid,
    output din_ready, dout_serial, dout_valid, dout_last
  );
endinterface

// File: rtl/parallel_to_serial_hold_buf.sv
// One-word holding buffer; a simultaneous read and write replaces the stored word.
module p2s_hold_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (wr_en) begin
      data_d = wr_data;
      full_d = 1'b1;
    end else if (rd_en) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;

endmodule

// File: rtl/parallel_to_serial.sv
// Word-to-bitstream serializer with a one-word holding buffer for gapless back-to-back words.
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int unsigned DATA_W    = P2S_DATA_W,
  parameter bit          MSB_FIRST = P2S_MSB_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_parallel,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout_serial,
  output logic              dout_valid,
  output logic              dout_last
);

  localparam int unsigned CNT_W = p2s_cnt_w(DATA_W);

  p2s_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              buf_wr, buf_rd, buf_full;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] shreg_next;
  logic              shifting, last_bit, out_bit, accept;

  p2s_hold_buf #(.DATA_W(DATA_W)) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (din_parallel),
    .rd_en   (buf_rd),
    .rd_data (buf_data),
    .full    (buf_full)
  );

  assign shifting   = (state_q == SHIFT);
  assign last_bit   = shifting && (cnt_q == CNT_W'(DATA_W - 1));
  assign out_bit    = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
  assign shreg_next = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};

  // Ready depends on registered state only, so it never loops back through din_valid.
  assign din_ready   = !buf_full || last_bit;
  assign accept      = din_valid && din_ready;
  assign dout_valid  = shifting;
  assign dout_serial = shifting && out_bit;
  assign dout_last   = last_bit;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    buf_wr  = 1'b0;
    buf_rd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din_parallel;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d = shreg_next;
          cnt_d   = cnt_q + CNT_W'(1);
          buf_wr  = accept;
        end else begin
          cnt_d = '0;
          // Buffered word goes first; a word accepted now takes its place in the buffer.
          if (buf_full) begin
            shreg_d = buf_data;
            buf_rd  = 1'b1;
            buf_wr  = accept;
          end else if (accept) begin
            shreg_d = din_parallel;
          end else begin
            shreg_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed checks of parallel_to_serial (MSB- and LSB-first) plus a random loopback into a receiver model.
module tb_parallel_to_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  parallel_to_serial_if #(.DATA_W(8)) bus_m ();
  parallel_to_serial_if #(.DATA_W(8)) bus_l ();

  parallel_to_serial #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk          (clk),
    .rst          (rst),
    .din_parallel (bus_m.din_parallel),
    .din_valid    (bus_m.din_valid),
    .din_ready    (bus_m.din_ready),
    .dout_serial  (bus_m.dout_serial),
    .dout_valid   (bus_m.dout_valid),
    .dout_last    (bus_m.dout_last)
  );

  parallel_to_serial #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk          (clk),
    .rst          (rst),
    .din_parallel (bus_l.din_parallel),
    .din_valid    (bus_l.din_valid),
    .din_ready    (bus_l.din_ready),
    .dout_serial  (bus_l.dout_serial),
    .dout_valid   (bus_l.dout_valid),
    .dout_last    (bus_l.dout_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_m(input string tag);
    chk_bit({tag, "_valid"}, bus_m.dout_valid, 1'b0);
    chk_bit({tag, "_serial"}, bus_m.dout_serial, 1'b0);
    chk_bit({tag, "_last"}, bus_m.dout_last, 1'b0);
    chk_bit({tag, "_ready"}, bus_m.din_ready, 1'b1);
  endtask

  // Feeds up to three words; offer[k]/rdy[k] give the offer pattern and the
  // hand-derived din_ready for output cycle k after the first accept.
  task automatic run_burst(input int unsigned n, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [23:0] offer,
                           input logic [23:0] rdy, input string tag);
    logic [7:0]  w [3];
    logic [23:0] stream;
    int unsigned idx;
    logic        take;
    w[0] = w0; w[1] = w1; w[2] = w2;
    stream = {w0, w1, w2};
    chk_bit({tag, "_ready0"}, bus_m.din_ready, 1'b1);
    bus_m.din_parallel = w[0];
    bus_m.din_valid    = 1'b1;
    tick();
    idx = 1;
    for (int unsigned k = 0; k < 8 * n; k++) begin
      if (idx < n && offer[k]) begin
        bus_m.din_parallel = w[idx];
        bus_m.din_valid    = 1'b1;
      end else begin
        bus_m.din_valid = 1'b0;
      end
      chk_bit({tag, "_serial"}, bus_m.dout_serial, stream[23 - k]);
      chk_bit({tag, "_valid"}, bus_m.dout_valid, 1'b1);
      chk_bit({tag, "_last"}, bus_m.dout_last, (k % 8) == 7);
      chk_bit({tag, "_ready"}, bus_m.din_ready, rdy[k]);
      take = bus_m.din_valid && rdy[k];
      tick();
      if (take) idx++;
    end
    bus_m.din_valid = 1'b0;
    check_idle_m({tag, "_end"});
  endtask

  initial begin
    logic [7:0] lsb_words [2];
    logic [7:0] exp_q [$];
    logic [7:0] cur, rx, exp_w;
    int unsigned nbits, sent, rcvd, cyc;

    bus_m.din_parallel = 8'h00;
    bus_m.din_valid    = 1'b0;
    bus_l.din_parallel = 8'h00;
    bus_l.din_valid    = 1'b0;

    // Reset with din_valid asserted: the word must be ignored.
    rst = 1'b1;
    bus_m.din_parallel = 8'hAA;
    bus_m.din_valid    = 1'b1;
    tick();
    check_idle_m("rst_during");
    tick();
    rst = 1'b0;
    bus_m.din_valid = 1'b0;
    check_idle_m("rst_after");
    tick();
    check_idle_m("rst_idle");

    // Single word, no follow-on.
    run_burst(1, 8'hF0, 8'h00, 8'h00, 24'h000000, 24'h0000FF, "single");
    // Back-to-back through the holding buffer.
    run_burst(2, 8'hF0, 8'hC3, 8'h00, 24'hFFFFFF, 24'h00FF81, "b2b");
    // Continuous offer with backpressure; buffer refilled on the last-bit cycle.
    run_burst(3, 8'hAA, 8'h55, 8'hFF, 24'hFFFFFF, 24'hFF8081, "bp");
    // Empty buffer, word offered only on the last-bit cycle: direct load.
    run_burst(2, 8'h81, 8'h3C, 8'h00, 24'h000080, 24'h00FFFF, "direct");

    // Reset on the 4th bit with a word sitting in the buffer.
    bus_m.din_parallel = 8'hFF;
    bus_m.din_valid    = 1'b1;
    tick();
    bus_m.din_parallel = 8'h0F;
    chk_bit("midrst_b0", bus_m.dout_serial, 1'b1);
    tick();
    bus_m.din_valid = 1'b0;
    chk_bit("midrst_b1", bus_m.dout_serial, 1'b1);
    tick();
    chk_bit("midrst_b2", bus_m.dout_serial, 1'b1);
    tick();
    chk_bit("midrst_b3", bus_m.dout_serial, 1'b1);
    chk_bit("midrst_ready_full", bus_m.din_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_m("midrst_post");
    for (int unsigned i = 0; i < 12; i++) begin
      tick();
      chk_bit("midrst_quiet_valid", bus_m.dout_valid, 1'b0);
      chk_bit("midrst_quiet_serial", bus_m.dout_serial, 1'b0);
    end

    // LSB-first instance.
    lsb_words[0] = 8'h01;
    lsb_words[1] = 8'hB4;
    for (int unsigned j = 0; j < 2; j++) begin
      chk_bit("lsb_ready", bus_l.din_ready, 1'b1);
      bus_l.din_parallel = lsb_words[j];
      bus_l.din_valid    = 1'b1;
      tick();
      bus_l.din_valid = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
        chk_bit("lsb_serial", bus_l.dout_serial, lsb_words[j][k]);
        chk_bit("lsb_valid", bus_l.dout_valid, 1'b1);
        chk_bit("lsb_last", bus_l.dout_last, k == 7);
        tick();
      end
      chk_bit("lsb_end_valid", bus_l.dout_valid, 1'b0);
    end

    // Loopback of 256 random words into a receiver model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sent  = 0;
    rcvd  = 0;
    cyc   = 0;
    nbits = 0;
    rx    = 8'h00;
    cur   = 8'($urandom);
    while (rcvd < 256 && cyc < 20000) begin
      if (bus_m.dout_valid) begin
        rx = {rx[6:0], bus_m.dout_serial};
        nbits++;
        if (bus_m.dout_last) begin
          chk_int("lb_len", nbits, 8);
          exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          chk_word("lb_word", rx, exp_w);
          rcvd++;
          nbits = 0;
        end
      end
      if (sent < 256 && $urandom_range(3) != 0) begin
        bus_m.din_parallel = cur;
        bus_m.din_valid    = 1'b1;
      end else begin
        bus_m.din_valid = 1'b0;
      end
      if (bus_m.din_valid && bus_m.din_ready) begin
        exp_q.push_back(cur);
        sent++;
        cur = 8'($urandom);
      end
      tick();
      cyc++;
    end
    bus_m.din_valid = 1'b0;
    chk_int("lb_count", rcvd, 256);
    chk_int("lb_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
